// File: rtl/galaksija_sysctl.sv
// galaksija_sysctl: system controller for the Galaksija core.
// Provides the CPU reset stretcher, a programmable periodic interrupt with a
// Z80 acknowledge handshake and missed-tick counting, and a bank of
// memory-mapped 8-bit output latches with readback.
//
// Optional feature: define SYSCTL_WATCHDOG_EN to build in a watchdog that
// soft-resets the CPU when no ctrl write arrives within WDT_CYCLES clocks.
//
// Ports:
//   clk, reset_n          system clock, asynchronous active-low reset
//   addr, odata           CPU address / write data
//   mreq_n, iorq_n, m1_n  CPU bus cycle qualifiers (ack = ~m1_n & ~iorq_n)
//   rd_n, wr_n            CPU read / write strobes
//   cpu_resetn            stretched CPU reset, active low (registered)
//   int_n                 maskable interrupt, active low (registered)
//   latch_q               latch outputs, latch i at [8i+7:8i] (registered)
//   rd_data, rd_hit       combinational readback for the top-level idata mux
module galaksija_sysctl #(
  parameter int unsigned F_CLK       = 25000000,
  parameter int unsigned INT_HZ      = 50,
  parameter int unsigned INT_HOLD    = 256,
  parameter int unsigned RST_CYCLES  = 64,
  parameter int unsigned LATCH_COUNT = 2,
  parameter logic [15:0] LATCH_BASE  = 16'h2038,
  parameter logic [15:0] CTRL_ADDR   = 16'h2040,
  parameter int unsigned WDT_CYCLES  = 25000000
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [15:0]              addr,
  input  logic [7:0]               odata,
  input  logic                     mreq_n,
  input  logic                     iorq_n,
  input  logic                     m1_n,
  input  logic                     rd_n,
  input  logic                     wr_n,
  output logic                     cpu_resetn,
  output logic                     int_n,
  output logic [8*LATCH_COUNT-1:0] latch_q,
  output logic [7:0]               rd_data,
  output logic                     rd_hit
);

  localparam int unsigned DIV    = F_CLK / INT_HZ - 1;
  localparam int unsigned DIV_W  = (DIV > 0) ? $clog2(DIV + 1) : 1;
  localparam int unsigned HOLD_W = (INT_HOLD > 1) ? $clog2(INT_HOLD) : 1;
  localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned MISS_W = 6;

  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ASSERT = 1'b1
  } state_t;

  logic [LATCH_COUNT-1:0] latch_sel_c;
  logic                   latch_hit_c;
  logic                   ctrl_hit_c;
  logic                   wsel_c;
  logic                   wsel_q;
  logic                   we_c;
  logic                   ctrl_we_c;
  logic                   clr_c;
  logic                   soft_rst_c;
  logic                   wdt_fire_c;
  logic                   wdt_flag;
  logic                   ack_c;
  logic                   tick_c;
  logic                   enable;
  logic [7:0]             status_c;

  logic [RST_W-1:0]       rst_cnt;
  logic [DIV_W-1:0]       div_cnt;

  state_t                 state, state_nxt;
  logic [HOLD_W-1:0]      hold, hold_nxt;
  logic                   pending, pending_nxt;
  logic                   rearm, rearm_nxt;
  logic [MISS_W-1:0]      missed, missed_nxt;
  logic                   miss_inc_c;

  // Address decode
  always_comb begin
    latch_sel_c = '0;
    for (int i = 0; i < LATCH_COUNT; i++) begin
      latch_sel_c[i] = (addr == LATCH_BASE + 16'(i));
    end
  end

  assign latch_hit_c = |latch_sel_c;
  assign ctrl_hit_c  = (addr == CTRL_ADDR);

  // One write per bus cycle: act only on the rising edge of the select
  assign wsel_c     = ~mreq_n & ~wr_n & (latch_hit_c | ctrl_hit_c);
  assign we_c       = wsel_c & ~wsel_q;
  assign ctrl_we_c  = we_c & ctrl_hit_c;
  assign clr_c      = ctrl_we_c & odata[1];
  assign soft_rst_c = (ctrl_we_c & odata[7]) | wdt_fire_c;
  assign ack_c      = ~m1_n & ~iorq_n;

  // Readback
  assign status_c = {pending, enable, missed[5] | wdt_flag, missed[4:0]};
  assign rd_hit   = ~mreq_n & ~rd_n & (latch_hit_c | ctrl_hit_c);

  always_comb begin
    rd_data = 8'h00;
    for (int i = 0; i < LATCH_COUNT; i++) begin
      if (latch_sel_c[i]) rd_data = latch_q[8*i +: 8];
    end
    if (ctrl_hit_c) rd_data = status_c;
  end

  // Write-select edge detect, enable bit and output latches
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wsel_q  <= 1'b0;
      enable  <= 1'b0;
      latch_q <= '0;
    end else begin
      wsel_q <= wsel_c;
      if (ctrl_we_c) enable <= odata[0];
      for (int i = 0; i < LATCH_COUNT; i++) begin
        if (we_c && latch_sel_c[i]) latch_q[8*i +: 8] <= odata;
      end
    end
  end

  // Reset stretcher: cpu_resetn rises RST_CYCLES clocks after release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_cnt    <= '0;
      cpu_resetn <= 1'b0;
    end else if (soft_rst_c) begin
      rst_cnt    <= '0;
      cpu_resetn <= 1'b0;
    end else if (!cpu_resetn) begin
      if (rst_cnt == RST_W'(RST_CYCLES - 1)) cpu_resetn <= 1'b1;
      else                                   rst_cnt    <= rst_cnt + RST_W'(1);
    end
  end

  // Tick divider, held at zero while the CPU is in reset
  assign tick_c = cpu_resetn & (div_cnt == DIV_W'(DIV));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (soft_rst_c || !cpu_resetn || tick_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Interrupt FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      hold    <= '0;
      pending <= 1'b0;
      rearm   <= 1'b0;
      missed  <= '0;
      int_n   <= 1'b1;
    end else begin
      state   <= state_nxt;
      hold    <= hold_nxt;
      pending <= pending_nxt;
      rearm   <= rearm_nxt;
      missed  <= missed_nxt;
      int_n   <= (state_nxt != S_ASSERT);
    end
  end

  // Interrupt FSM: next state
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    pending_nxt = pending;
    rearm_nxt   = 1'b0;
    miss_inc_c  = 1'b0;

    case (state)
      S_IDLE: begin
        // rearm carries a tick that coincided with an ack
        if (enable && (tick_c || rearm)) begin
          state_nxt   = S_ASSERT;
          hold_nxt    = '0;
          pending_nxt = 1'b1;
        end
      end
      S_ASSERT: begin
        if (!enable) begin
          state_nxt   = S_IDLE;
          pending_nxt = 1'b0;
        end else if (ack_c) begin
          // int_n goes high for one clock; a same-cycle tick re-raises it
          state_nxt   = S_IDLE;
          pending_nxt = 1'b0;
          rearm_nxt   = tick_c;
        end else if (hold == HOLD_W'(INT_HOLD - 1)) begin
          miss_inc_c = 1'b1;
          hold_nxt   = '0;
          if (!tick_c) begin
            state_nxt   = S_IDLE;
            pending_nxt = 1'b0;
          end
        end else begin
          hold_nxt   = hold + HOLD_W'(1);
          miss_inc_c = tick_c;
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    missed_nxt = (miss_inc_c && (missed != '1)) ? missed + MISS_W'(1) : missed;

    if (clr_c) begin
      missed_nxt  = '0;
      pending_nxt = 1'b0;
    end

    if (soft_rst_c) begin
      state_nxt   = S_IDLE;
      hold_nxt    = '0;
      pending_nxt = 1'b0;
      rearm_nxt   = 1'b0;
    end
  end

`ifdef SYSCTL_WATCHDOG_EN
  localparam int unsigned WDT_W = (WDT_CYCLES > 1) ? $clog2(WDT_CYCLES) : 1;

  logic [WDT_W-1:0] wdt_cnt;

  // Watchdog: any ctrl write restarts it; expiry soft-resets the CPU
  assign wdt_fire_c = cpu_resetn & ~ctrl_we_c & (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdt_cnt  <= '0;
      wdt_flag <= 1'b0;
    end else begin
      if (!cpu_resetn || ctrl_we_c || wdt_fire_c) wdt_cnt <= '0;
      else                                        wdt_cnt <= wdt_cnt + WDT_W'(1);
      if (wdt_fire_c)  wdt_flag <= 1'b1;
      else if (clr_c)  wdt_flag <= 1'b0;
    end
  end
`else
  logic unused_wdt_cfg;

  assign wdt_fire_c = 1'b0;
  assign wdt_flag   = 1'b0;
  // WDT_CYCLES is only consumed when the watchdog is built in
  assign unused_wdt_cfg = ^WDT_CYCLES;
`endif

endmodule

// File: tb/tb_galaksija_sysctl.sv
// Directed bench for galaksija_sysctl: latch table plus hand-written
// interrupt / reset sequences. A second instance uses INT_HOLD equal to the
// tick period so that timeouts and acks can coincide with ticks.
module tb_galaksija_sysctl;

  localparam logic [15:0] CTRL = 16'h2040;

  logic        clk;
  logic        reset_n;
  logic [15:0] addr;
  logic [7:0]  odata;
  logic        mreq_n, iorq_n, m1_n, rd_n, wr_n;

  logic        cpu_resetn, int_n, rd_hit;
  logic [15:0] latch_q;
  logic [7:0]  rd_data;
  logic        cpu_resetn2, int_n2, rd_hit2;
  logic [15:0] latch_q2;
  logic [7:0]  rd_data2;

  galaksija_sysctl #(
    .F_CLK(1000), .INT_HZ(10), .INT_HOLD(8), .RST_CYCLES(64), .LATCH_COUNT(2),
    .LATCH_BASE(16'h2038), .CTRL_ADDR(16'h2040), .WDT_CYCLES(25000000)
  ) u_dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .odata(odata),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .cpu_resetn(cpu_resetn), .int_n(int_n), .latch_q(latch_q),
    .rd_data(rd_data), .rd_hit(rd_hit)
  );

  galaksija_sysctl #(
    .F_CLK(1000), .INT_HZ(10), .INT_HOLD(100), .RST_CYCLES(64), .LATCH_COUNT(2),
    .LATCH_BASE(16'h2038), .CTRL_ADDR(16'h2040), .WDT_CYCLES(25000000)
  ) u_dut_hold (
    .clk(clk), .reset_n(reset_n), .addr(addr), .odata(odata),
    .mreq_n(mreq_n), .iorq_n(iorq_n), .m1_n(m1_n), .rd_n(rd_n), .wr_n(wr_n),
    .cpu_resetn(cpu_resetn2), .int_n(int_n2), .latch_q(latch_q2),
    .rd_data(rd_data2), .rd_hit(rd_hit2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  d1;         // data on the first write clock
    logic [7:0]  d2;         // data on later clocks of the same write
    int          hold;
    logic        mem;        // 1: memory write, 0: I/O write
    logic        wr;
    logic        exp_hit;
    logic [7:0]  exp_rd;
    logic [15:0] exp_latch;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d1, input logic [7:0] d2,
                           input int hold, input logic mem);
    @(negedge clk);
    addr = a; odata = d1; mreq_n = ~mem; iorq_n = mem; wr_n = 1'b0;
    @(negedge clk);
    odata = d2;
    repeat (hold - 1) @(negedge clk);
    mreq_n = 1'b1; iorq_n = 1'b1; wr_n = 1'b1; odata = 8'h00;
  endtask

  task automatic bus_read(input logic [15:0] a, input bit second,
                          output logic hit, output logic [7:0] d);
    addr = a; mreq_n = 1'b0; rd_n = 1'b0;
    #1;
    hit = second ? rd_hit2 : rd_hit;
    d   = second ? rd_data2 : rd_data;
    mreq_n = 1'b1; rd_n = 1'b1;
  endtask

  task automatic wait_fall(input bit second, output int unsigned at);
    int unsigned n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((second ? int_n2 : int_n) !== 1'b0) && n < 300);
    at = cyc;
    check("int_fall_seen", 32'(second ? int_n2 : int_n), 32'd0);
  endtask

  initial begin
    logic        hit;
    logic [7:0]  d;
    logic [15:0] exp_latch;
    int unsigned n, w, t_fall, t_prev;

    reset_n = 1'b0; addr = 16'h0000; odata = 8'h00;
    mreq_n = 1'b1; iorq_n = 1'b1; m1_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    exp_latch = 16'h0000; t_prev = 0;

    vecs[0] = '{16'h2039, 8'hA5, 8'h77, 3, 1'b1, 1'b1, 1'b1, 8'hA5, 16'hA500};
    vecs[1] = '{16'h2038, 8'h3C, 8'h99, 1, 1'b1, 1'b1, 1'b1, 8'h3C, 16'hA53C};
    vecs[2] = '{16'h203A, 8'hFF, 8'hFF, 2, 1'b1, 1'b1, 1'b0, 8'h00, 16'hA53C};
    vecs[3] = '{16'h2037, 8'h11, 8'h11, 1, 1'b1, 1'b1, 1'b0, 8'h00, 16'hA53C};
    vecs[4] = '{16'h2038, 8'h66, 8'h66, 2, 1'b0, 1'b1, 1'b1, 8'h3C, 16'hA53C};
    vecs[5] = '{16'h2039, 8'h5A, 8'h12, 2, 1'b1, 1'b1, 1'b1, 8'h5A, 16'h5A3C};
    vecs[6] = '{16'h2040, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b1, 8'h00, 16'h5A3C};
    vecs[7] = '{16'h0000, 8'h00, 8'h00, 1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h5A3C};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_cpu_resetn", 32'(cpu_resetn), 32'd0);
    check("rst_int_n", 32'(int_n), 32'd1);
    check("rst_latch_q", 32'(latch_q), 32'd0);
    bus_read(CTRL, 1'b0, hit, d);
    check("rst_status_hit", 32'(hit), 32'd1);
    check("rst_status", 32'(d), 32'd0);

    // Reset stretch
    reset_n = 1'b1;
    n = 0;
    while (cpu_resetn !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cpu_resetn_stretch", 32'(n), 32'd64);

    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (int_n !== 1'b1 || int_n2 !== 1'b1) n++;
    end
    check("int_idle_when_disabled", 32'(n), 32'd0);

    // Latch table
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].d1, vecs[i].d2, vecs[i].hold, vecs[i].mem);
      else @(negedge clk);
      bus_read(vecs[i].addr, 1'b0, hit, d);
      check($sformatf("vec%0d_rd_hit", i), 32'(hit), 32'(vecs[i].exp_hit));
      if (vecs[i].exp_hit) check($sformatf("vec%0d_rd_data", i), 32'(d), 32'(vecs[i].exp_rd));
      check($sformatf("vec%0d_latch_q", i), 32'(latch_q), 32'(vecs[i].exp_latch));
      exp_latch = vecs[i].exp_latch;
    end

    // Enabled, never acknowledged
    bus_write(CTRL, 8'h01, 8'h01, 1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_fall(1'b0, t_fall);
      if (k > 0) check("tick_period", 32'(t_fall - t_prev), 32'd100);
      t_prev = t_fall;
      bus_read(CTRL, 1'b0, hit, d);
      check("assert_status", 32'(d), 32'(8'hC0 | 8'(k)));
      w = 1;
      while (w < 50) begin
        @(negedge clk);
        if (int_n !== 1'b0) break;
        w++;
      end
      check("int_low_width", 32'(w), 32'd8);
      bus_read(CTRL, 1'b0, hit, d);
      check("missed_count", 32'(d), 32'(8'h40 | 8'(k + 1)));
    end

    // Clear, then acknowledge on the third low clock
    bus_write(CTRL, 8'h03, 8'h03, 1, 1'b1);
    bus_read(CTRL, 1'b0, hit, d);
    check("clear_status", 32'(d), 32'h40);
    wait_fall(1'b0, t_fall);
    check("tick_period_after_clear", 32'(t_fall - t_prev), 32'd100);
    t_prev = t_fall;
    repeat (2) @(negedge clk);
    m1_n = 1'b0; iorq_n = 1'b0;
    @(negedge clk);
    m1_n = 1'b1; iorq_n = 1'b1;
    check("ack_int_rises", 32'(int_n), 32'd1);
    bus_read(CTRL, 1'b0, hit, d);
    check("ack_status", 32'(d), 32'h40);
    wait_fall(1'b0, t_fall);
    check("tick_period_after_ack", 32'(t_fall - t_prev), 32'd100);

    // Disable while asserted
    bus_write(CTRL, 8'h00, 8'h00, 1, 1'b1);
    check("disable_int_still_low", 32'(int_n), 32'd0);
    @(negedge clk);
    check("disable_int_released", 32'(int_n), 32'd1);
    bus_read(CTRL, 1'b0, hit, d);
    check("disable_status", 32'(d), 32'h00);

    // Timeout coinciding with tick, then ack coinciding with tick
    bus_write(CTRL, 8'h03, 8'h03, 1, 1'b1);
    wait_fall(1'b1, t_fall);
    bus_read(CTRL, 1'b1, hit, d);
    check("hold2_entry_status", 32'(d), 32'hC0);
    n = 0;
    repeat (150) begin
      @(negedge clk);
      if (int_n2 !== 1'b0) n++;
    end
    check("timeout_tick_stays_low", 32'(n), 32'd0);
    bus_read(CTRL, 1'b1, hit, d);
    check("timeout_tick_missed_once", 32'(d), 32'hC1);
    repeat (49) @(negedge clk);
    m1_n = 1'b0; iorq_n = 1'b0;
    @(negedge clk);
    m1_n = 1'b1; iorq_n = 1'b1;
    check("ack_tick_int_rises", 32'(int_n2), 32'd1);
    @(negedge clk);
    check("ack_tick_int_refalls", 32'(int_n2), 32'd0);
    bus_read(CTRL, 1'b1, hit, d);
    check("ack_tick_missed_unchanged", 32'(d), 32'hC1);

    // Soft reset with clear
    bus_write(CTRL, 8'h82, 8'h82, 1, 1'b1);
    check("soft_cpu_resetn_low", 32'(cpu_resetn), 32'd0);
    check("soft_int_n", 32'(int_n), 32'd1);
    check("soft_int_n2", 32'(int_n2), 32'd1);
    n = 0;
    while (cpu_resetn !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("soft_reset_stretch", 32'(n), 32'd64);
    bus_read(CTRL, 1'b0, hit, d);
    check("soft_status", 32'(d), 32'h00);
    bus_read(CTRL, 1'b1, hit, d);
    check("soft_status2", 32'(d), 32'h00);
    check("soft_latch_kept", 32'(latch_q), 32'(exp_latch));
    check("soft_latch_kept2", 32'(latch_q2), 32'(exp_latch));

    // Asynchronous reset in the middle of an assertion
    bus_write(CTRL, 8'h01, 8'h01, 1, 1'b1);
    wait_fall(1'b0, t_fall);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_int_n", 32'(int_n), 32'd1);
    check("async_int_n2", 32'(int_n2), 32'd1);
    check("async_latch_q", 32'(latch_q), 32'd0);
    check("async_latch_q2", 32'(latch_q2), 32'd0);
    check("async_cpu_resetn", 32'(cpu_resetn), 32'd0);

    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
